// File: rtl/ir_err_pkg.sv
// Shared types and helpers for the IR steering-error sequencer.
package ir_err_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} ir_err_state_t;

  // Wide enough for the largest weighted sum of one side plus a sign bit.
  function automatic int unsigned acc_width(int unsigned num_ch, int unsigned ir_w);
    return ir_w + num_ch / 2 + 1;
  endfunction

  function automatic logic signed [63:0] sat_to(logic signed [63:0] val, int unsigned err_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (err_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (err_w - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/ir_err_accum.sv
// Signed accumulator applying positional shift/sign weights by channel select,
// with a saturated view of the running sum.
module ir_err_accum
  import ir_err_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned IR_W   = 12,
  parameter int unsigned ERR_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       add,
  input  logic [$clog2(NUM_CH)-1:0]  sel,
  input  logic [IR_W-1:0]            ir_data,
  output logic signed [ERR_W-1:0]    acc_sat
);

  localparam int unsigned IW = acc_width(NUM_CH, IR_W);

  logic signed [IW-1:0] acc_q;
  logic signed [IW-1:0] acc_d;
  logic signed [IW-1:0] term;

  // Pair index sel>>1 picks the shift; odd (left) sensors subtract.
  always_comb begin
    term = $signed({{(IW - IR_W){1'b0}}, ir_data}) <<< (sel >> 1);
    if (sel[0]) term = -term;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + term;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_sat = ERR_W'(sat_to(64'(acc_q), ERR_W));

endmodule

// File: rtl/ir_err_sequencer.sv
// Frame sequencer: walks the IR channels through the external mux, accumulates
// the weighted error and publishes a saturated result with overrun tracking.
module ir_err_sequencer
  import ir_err_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned IR_W   = 12,
  parameter int unsigned ERR_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       IR_vld,
  input  logic [IR_W-1:0]            ir_data,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic                       clr_ovr,
  output logic [$clog2(NUM_CH)-1:0]  sel,
  output logic                       busy,
  output logic signed [ERR_W-1:0]    err,
  output logic                       err_vld,
  output logic                       overrun
);

  localparam int unsigned SelW = $clog2(NUM_CH);

  ir_err_state_t           state_q;
  logic [NUM_CH-1:0]       en_q;
  logic                    start;
  logic                    ovr_evt;
  logic                    acc_add;
  logic signed [ERR_W-1:0] acc_sat;

  // The err_vld cycle counts as busy for start requests.
  assign start   = (state_q == StIdle) && IR_vld && !err_vld;
  assign ovr_evt = IR_vld && ((state_q != StIdle) || err_vld);
  assign acc_add = (state_q == StAccum) && en_q[sel];
  assign busy    = (state_q != StIdle);

  ir_err_accum #(
    .NUM_CH (NUM_CH),
    .IR_W   (IR_W),
    .ERR_W  (ERR_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .add     (acc_add),
    .sel     (sel),
    .ir_data (ir_data),
    .acc_sat (acc_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel     <= '0;
      en_q    <= '0;
      err     <= '0;
      err_vld <= 1'b0;
      overrun <= 1'b0;
    end else begin
      err_vld <= 1'b0;
      if (ovr_evt) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sel     <= '0;
            en_q    <= ch_en;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (sel == SelW'(NUM_CH - 1)) begin
            sel     <= '0;
            state_q <= StDone;
          end else begin
            sel <= sel + SelW'(1);
          end
        end
        StDone: begin
          err     <= acc_sat;
          err_vld <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_err_sequencer.sv
// Scoreboard bench for ir_err_sequencer with NUM_CH=8, IR_W=12, ERR_W=16.
module tb_ir_err_sequencer;

  logic               clk;
  logic               rst_n;
  logic               IR_vld;
  logic [11:0]        ir_data;
  logic [7:0]         ch_en;
  logic               clr_ovr;
  logic [2:0]         sel;
  logic               busy;
  logic signed [15:0] err;
  logic               err_vld;
  logic               overrun;

  logic [11:0] ch_val [8];
  int          exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  ir_err_sequencer #(
    .NUM_CH (8),
    .IR_W   (12),
    .ERR_W  (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .IR_vld  (IR_vld),
    .ir_data (ir_data),
    .ch_en   (ch_en),
    .clr_ovr (clr_ovr),
    .sel     (sel),
    .busy    (busy),
    .err     (err),
    .err_vld (err_vld),
    .overrun (overrun)
  );

  // External combinational mux
  assign ir_data = ch_val[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model(input logic [7:0] en);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) begin
        if (i % 2 == 0) acc += int'(ch_val[i]) * (1 << (i / 2));
        else            acc -= int'(ch_val[i]) * (1 << (i / 2));
      end
    end
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  always @(negedge clk) begin
    if (rst_n && err_vld) begin
      if (exp_q.size() == 0) check("spurious_err_vld", 1, 0);
      else                   check("err", int'(err), exp_q.pop_front());
    end
  end

  // ovr_at: cycle after start at which to raise IR_vld again (-1 = never, 9 = err_vld cycle)
  task automatic run_frame(input logic [7:0] en, input int ovr_at, input logic clr_same);
    int   lat;
    int   expv;
    logic sel_ok;
    expv = model(en);
    exp_q.push_back(expv);
    sel_ok = 1'b1;
    @(negedge clk);
    IR_vld = 1'b1;
    ch_en  = en;
    @(negedge clk);
    ch_en = '0;
    lat = 0;
    while (!err_vld && lat < 30) begin
      if (lat < 9 && (!busy || (lat < 8 && sel != 3'(lat)))) sel_ok = 1'b0;
      if (lat == ovr_at) begin
        IR_vld  = 1'b1;
        clr_ovr = clr_same;
      end else begin
        IR_vld  = 1'b0;
        clr_ovr = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 9);
    check("sel_seq_busy", int'(sel_ok), 1);
    if (ovr_at == 9) IR_vld = 1'b1;
    @(negedge clk);
    IR_vld  = 1'b0;
    clr_ovr = 1'b0;
    check("vld_pulse", int'(err_vld), 0);
    check("err_hold", int'(err), expv);
    check("idle_after", int'(busy), 0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    IR_vld  = 1'b0;
    ch_en   = '0;
    clr_ovr = 1'b0;
    ch_val  = '{default: 12'd0};
    repeat (2) @(negedge clk);
    check("rst_err", int'(err), 0);
    check("rst_vld", int'(err_vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_sel", int'(sel), 0);
    rst_n = 1'b1;
    @(negedge clk);

    ch_val = '{default: 12'd100};
    run_frame(8'hFF, -1, 1'b0);

    ch_val    = '{default: 12'd0};
    ch_val[0] = 12'd1000;
    ch_val[1] = 12'd200;
    ch_val[6] = 12'd50;
    run_frame(8'hFF, -1, 1'b0);
    run_frame(8'hFE, -1, 1'b0);

    for (int i = 0; i < 8; i++) ch_val[i] = (i % 2 == 0) ? 12'd4095 : 12'd0;
    run_frame(8'hFF, -1, 1'b0);
    for (int i = 0; i < 8; i++) ch_val[i] = (i % 2 == 1) ? 12'd4095 : 12'd0;
    run_frame(8'hFF, -1, 1'b0);
    check("no_ovr_yet", int'(overrun), 0);

    ch_val    = '{default: 12'd0};
    ch_val[0] = 12'd1000;
    ch_val[1] = 12'd200;
    ch_val[6] = 12'd50;
    run_frame(8'hFF, 3, 1'b0);
    check("ovr_set", int'(overrun), 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_clr", int'(overrun), 0);
    run_frame(8'h0F, 3, 1'b1);
    check("ovr_set_wins", int'(overrun), 1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_clr2", int'(overrun), 0);
    run_frame(8'hFF, 9, 1'b0);
    check("ovr_vld_cycle", int'(overrun), 1);

    // Mid-frame reset at sel=4
    @(negedge clk);
    IR_vld = 1'b1;
    ch_en  = 8'hFF;
    @(negedge clk);
    IR_vld = 1'b0;
    n = 0;
    while (sel != 3'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_sel4", int'(sel), 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_vld", int'(err_vld), 0);
    check("mid_rst_sel", int'(sel), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ovr", int'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_frame(8'hFF, -1, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ir_err_sequencer.md
# ir_err_sequencer

Parametrised sequencer and weighted accumulator that turns one frame of IR sensor readings into a signed steering error. It sits between the IR sensor interface, which supplies one reading per channel through an external mux driven by `sel`, and the steering PID, which consumes `err` on `err_vld`. Compared with the previous fixed 8-channel sequencer, it owns the accumulator, applies positional weights, supports a channel-enable mask, saturates the result and flags frames that arrive while a computation is still running.

## Interface
- `NUM_CH`, 8, number of IR channels; even, 2..16
- `IR_W`, 12, unsigned IR reading width
- `ERR_W`, 16, signed output error width
- `clk` input 1, clock
- `rst_n` input 1, reset, asynchronous, active-low
- `IR_vld` input 1, new IR frame ready; start request
- `ir_data` input IR_W, unsigned reading of channel `sel` (external mux, combinational)
- `ch_en` input NUM_CH, per-channel enable; sampled with `IR_vld`
- `clr_ovr` input 1, clears `overrun`
- `sel` output $clog2(NUM_CH), channel select to external mux
- `busy` output 1, high while not IDLE
- `err` output ERR_W signed, last completed error; held between frames
- `err_vld` output 1, one-cycle pulse when `err` updates
- `overrun` output 1, sticky: `IR_vld` seen while busy

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - On `IR_vld`, clear the accumulator, set `sel` to 0, latch `ch_en` into `en_q`, and go to ACCUM.
- ACCUM: one channel per cycle.
  - acc += w(sel) * ir_data if `en_q[sel]`; otherwise the contribution is 0, but the cycle is still consumed.
  - `sel` increments each cycle. After `sel` = NUM_CH-1, go to DONE and return `sel` to 0.
- Weight rule: pair p = sel>>1, magnitude 2^p (shift, no multiplier). Even sel (right sensor) adds; odd sel (left sensor) subtracts.
- Internal accumulator width IW = IR_W + NUM_CH/2 + 1, signed. No internal overflow is possible.
- DONE: `err` <= sat(acc) to the ERR_W signed range, i.e. clamp to [-2^(ERR_W-1), 2^(ERR_W-1)-1]. `err_vld` <= 1. Next state IDLE.
- Overrun:
  - `IR_vld` in ACCUM or DONE is ignored for computation and sets `overrun`.
  - `clr_ovr` clears `overrun`. If `clr_ovr` and an overrun event occur in the same cycle, set wins.
- Reset values: state IDLE, `sel` 0, acc 0, `err` 0, `err_vld` 0, `busy` 0, `overrun` 0, `en_q` 0.
- Reset mid-operation aborts the frame immediately. No `err_vld` is produced, and `err` returns to 0.

## Timing
- `IR_vld` sampled high in IDLE at edge T:
  - ACCUM covers the cycles between edges T+1 .. T+NUM_CH, with `sel` = 0..NUM_CH-1.
  - `err` and `err_vld` are registered and visible for exactly one cycle after edge T+NUM_CH+1.
- Latency from `IR_vld` to `err_vld` is NUM_CH+1 cycles.
- `busy` is high from T+1 until the DONE cycle, inclusive.
- `IR_vld` during the `err_vld` cycle is treated as IDLE-adjacent and ignored; it sets `overrun`. The earliest accepted next start is the cycle after `err_vld`, giving a throughput of one frame per NUM_CH+2 cycles.
- `ir_data` must be valid in the same cycle as the `sel` value it corresponds to. There is no pipeline register on the input.
- All outputs are registered except `busy`, which decodes from the state register.

## Structure
- Package `ir_err_pkg`:
  - state enum `ir_err_state_t` {IDLE, ACCUM, DONE}
  - function `acc_width(NUM_CH, IR_W)`
  - saturation function `sat_to(ERR_W)`
- Sub-module `ir_err_accum`: signed accumulator with clear, enable, shift/sign weighting by `sel`, and the final saturation. The top module holds the FSM, `sel` counter, `en_q` and the overrun logic.

## Test plan
All scenarios use NUM_CH=8, IR_W=12, ERR_W=16.

- Reset: all outputs 0. Pulse `IR_vld` with all `ir_data`=100 and `ch_en`=8'hFF -> `err`=0 and `err_vld` high exactly 9 cycles later for 1 cycle.
- Asymmetric frame: ch0=1000, ch1=200, ch6=50, others 0, all enabled -> `err` = 1000 - 200 + 8*50 = 1200.
- Mask: same frame as the asymmetric case with `ch_en`=8'b1111_1110 -> `err` = -200 + 400 = 200. The `sel` sequence is still 0..7.
- Saturation: even channels 4095, odd channels 0 -> raw 61425, so `err`=32767. Mirrored frame -> `err`=-32768.
- Overrun: `IR_vld` at cycle 3 of ACCUM -> frame result unaffected and `overrun`=1. `clr_ovr` -> `overrun`=0. Simultaneous `clr_ovr` and overrun event -> `overrun`=1.
- Mid-frame reset: assert `rst_n` low while `sel`=4 -> no `err_vld`, `err`=0, `sel`=0. A restart produces a correct result.
